// File: rtl/top_servo_ctrl.sv
// 50 Hz servo PWM with a proportional angle correction and per-frame over-current blanking.
// Latency: inputs sampled once per frame at the wrap edge; no handshake, never stalls.
module top_servo_ctrl #(
  parameter int  PWM_PERIOD_CYC = 2000000,
  parameter int  MIN_PULSE_CYC  = 100000,
  parameter int  STEP_CYC       = 555,
  parameter int  MAX_DEG        = 180,
  parameter int  KP_SHIFT       = 1,
  parameter real I_LIMIT        = 2.0
) (
  input  logic clk,
  input  logic rst_n,
  input  real  grades,
  input  real  measure_current,
  input  real  measure_grades,
  output logic pwm_out
);

  localparam int AW     = 11;
  localparam int PW_MAX = MIN_PULSE_CYC + MAX_DEG * STEP_CYC;
  localparam int CNT_W  = $clog2(PWM_PERIOD_CYC);
  localparam int PW_W   = $clog2(PW_MAX + 1);
  localparam int W      = (CNT_W > PW_W) ? CNT_W : PW_W;

  localparam logic signed [AW-1:0] MAX_Q = AW'(MAX_DEG);
  localparam logic [W-1:0]         LAST  = W'(PWM_PERIOD_CYC - 1);

  // Clamp in the real domain first so out-of-range inputs never overflow $rtoi.
  function automatic logic signed [AW-1:0] quant_deg(input real v);
    if (v <= 0.0)
      return '0;
    else if (v >= real'(MAX_DEG))
      return MAX_Q;
    else
      return AW'($rtoi(v));
  endfunction

  logic signed [AW-1:0] g_q;
  logic signed [AW-1:0] m_q;
  logic signed [AW-1:0] e;
  logic signed [AW-1:0] t;
  logic        [AW-1:0] t_c;
  logic        [W-1:0]  width;
  logic                 oc_now;

  logic [W-1:0] cnt;
  logic [W-1:0] pulse_reg;
  logic         oc_reg;
  logic         frame_end;

  always_comb begin
    g_q = quant_deg(grades);
    m_q = quant_deg(measure_grades);
    e   = g_q - m_q;
    t   = g_q + (e >>> KP_SHIFT);
    if (t < 0)
      t_c = '0;
    else if (t > MAX_Q)
      t_c = MAX_Q;
    else
      t_c = t;
    width  = W'(MIN_PULSE_CYC) + W'(t_c) * W'(STEP_CYC);
    oc_now = (measure_current > I_LIMIT);
  end

  assign frame_end = (cnt == LAST);

  // Reset is active-high despite the port name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt       <= '0;
      pulse_reg <= '0;
      oc_reg    <= 1'b0;
    end else if (frame_end) begin
      cnt       <= '0;
      pulse_reg <= width;
      oc_reg    <= oc_now;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign pwm_out = !oc_reg && (cnt < pulse_reg);

endmodule

// File: tb/tb_top_servo_ctrl.sv
// Directed bench for top_servo_ctrl using a shortened frame (1200 cycles, 100 + 5/deg).
module tb_top_servo_ctrl;

  localparam int P = 1200;

  logic clk;
  logic rst_n;
  real  grades;
  real  measure_current;
  real  measure_grades;
  logic pwm_out;

  int n_tests = 0;
  int n_fail  = 0;

  top_servo_ctrl #(
    .PWM_PERIOD_CYC(P),
    .MIN_PULSE_CYC (100),
    .STEP_CYC      (5),
    .MAX_DEG       (180),
    .KP_SHIFT      (1),
    .I_LIMIT       (2.0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .grades         (grades),
    .measure_current(measure_current),
    .measure_grades (measure_grades),
    .pwm_out        (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    real g;
    real m;
    real i;
    int  exp_hi;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at the negedge of a frame's cnt=0 cycle; returns at the next frame's cnt=0 negedge.
  task automatic measure(input int chg_at, input real chg_g, output int hi, output int contig);
    bit seen_low;
    hi       = 0;
    contig   = 1;
    seen_low = 0;
    for (int k = 0; k < P; k++) begin
      if (k == chg_at) grades = chg_g;
      if (pwm_out === 1'b1) begin
        hi++;
        if (seen_low) contig = 0;
      end else begin
        seen_low = 1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int hi, contig, prev_exp;

    // hi count = 100 + 5 * clamp(g + ((g - m) >>> 1)), zero under over-current
    vecs[0]  = '{g:  90.0, m:   0.0, i: 1.0, exp_hi:  775};
    vecs[1]  = '{g:  90.0, m:  90.0, i: 1.0, exp_hi:  550};
    vecs[2]  = '{g: 180.0, m:   0.0, i: 1.0, exp_hi: 1000};
    vecs[3]  = '{g:   0.0, m: 180.0, i: 1.0, exp_hi:  100};
    vecs[4]  = '{g: 250.0, m: 200.0, i: 1.0, exp_hi: 1000};
    vecs[5]  = '{g: -10.0, m:   0.0, i: 1.0, exp_hi:  100};
    vecs[6]  = '{g:  90.0, m:   0.0, i: 2.5, exp_hi:    0};
    vecs[7]  = '{g:  90.0, m:   0.0, i: 1.0, exp_hi:  775};
    vecs[8]  = '{g:  90.0, m:   0.0, i: 2.0, exp_hi:  775};
    vecs[9]  = '{g:  45.9, m:  10.7, i: 1.0, exp_hi:  410};
    vecs[10] = '{g:  10.0, m:  11.0, i: 1.0, exp_hi:  145};
    vecs[11] = '{g:  20.0, m:  -5.5, i: 1.0, exp_hi:  250};
    vecs[12] = '{g: 100.0, m:  60.0, i: 1.0, exp_hi:  700};

    rst_n           = 1'b1;
    grades          = 90.0;
    measure_grades  = 0.0;
    measure_current = 1.0;

    // Reset held for two edges, then first frame idle, then the 775-cycle pulse.
    @(negedge clk);
    check("pwm_in_reset_0", int'(pwm_out), 0);
    @(negedge clk);
    check("pwm_in_reset_1", int'(pwm_out), 0);
    rst_n = 1'b0;
    measure(-1, 0.0, hi, contig);
    check("first_frame_idle", hi, 0);
    measure(-1, 0.0, hi, contig);
    check("frame2_hi", hi, 775);
    check("frame2_contig", contig, 1);
    prev_exp = 775;

    for (int v = 0; v < 13; v++) begin
      grades          = vecs[v].g;
      measure_grades  = vecs[v].m;
      measure_current = vecs[v].i;
      measure(-1, 0.0, hi, contig);
      check($sformatf("vec%0d_hold_prev", v), hi, prev_exp);
      measure(-1, 0.0, hi, contig);
      check($sformatf("vec%0d_hi", v), hi, vecs[v].exp_hi);
      check($sformatf("vec%0d_contig", v), contig, 1);
      prev_exp = vecs[v].exp_hi;
    end

    // Mid-pulse command change must not disturb the frame in progress.
    grades          = 90.0;
    measure_grades  = 0.0;
    measure_current = 1.0;
    measure(-1, 0.0, hi, contig);
    check("pre_change_frame", hi, 700);
    measure(200, 0.0, hi, contig);
    check("midpulse_frame_kept", hi, 775);
    measure(-1, 0.0, hi, contig);
    check("midpulse_next_frame", hi, 100);

    // Reset asserted during the high phase.
    grades = 90.0;
    measure(-1, 0.0, hi, contig);
    check("pre_reset_frame", hi, 100);
    for (int k = 0; k < 120; k++) @(negedge clk);
    check("pwm_high_before_reset", int'(pwm_out), 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("pwm_low_after_reset_edge", int'(pwm_out), 0);
    @(negedge clk);
    check("pwm_low_reset_hold", int'(pwm_out), 0);
    rst_n = 1'b0;
    measure(-1, 0.0, hi, contig);
    check("post_reset_idle", hi, 0);
    measure(-1, 0.0, hi, contig);
    check("post_reset_pulse", hi, 775);
    check("post_reset_contig", contig, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/top_servo_ctrl.md
Name: top_servo_ctrl

Overview:
Closed-loop hobby-servo PWM generator. Takes a commanded angle (degrees), the measured shaft angle and the measured motor current. It produces a 50 Hz PWM whose pulse width encodes a proportionally corrected angle target. Over-current suppresses the pulse. It sits at the top of the servo subsystem, between the host command and the servo power stage.

Parameters:
PWM_PERIOD_CYC, 2000000, clock cycles per PWM frame (20 ms at a 100 MHz clk).
MIN_PULSE_CYC, 100000, high time for a 0 degree target (1 ms).
STEP_CYC, 555, high-time cycles added per degree (integer; 180 degrees gives 199900).
MAX_DEG, 180, upper angle clamp.
KP_SHIFT, 1, proportional gain as an arithmetic right shift of the error (gain 0.5).
I_LIMIT, 2.0, real, over-current threshold in amperes.

Ports:
clk  input  1  single clock, rising edge; 10 ns period in the system bench.
rst_n  input  1  reset; synchronous, active-high (asserted = 1) despite the name.
grades  input  real  commanded angle, degrees.
measure_current  input  real  measured motor current, amperes.
measure_grades  input  real  measured shaft angle, degrees.
pwm_out  output  1  servo PWM.

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - frame counter cnt=0, pulse_reg=0, oc_reg=0.
  - pwm_out=0 from that edge onward; reset mid-pulse forces pwm_out low after that edge.
- cnt: increments each cycle while not in reset; wraps PWM_PERIOD_CYC-1 -> 0.
- Quantization, combinational and continuous:
  - g_q = grades truncated toward zero to an integer, clamped to [0, MAX_DEG].
  - m_q = same rule applied to measure_grades.
  - Negative values map to 0; values above MAX_DEG map to MAX_DEG.
- Control law, signed arithmetic, at least 11 bits:
  - e = g_q - m_q, range -180..180.
  - t = g_q + (e >>> KP_SHIFT), arithmetic shift, rounds toward -inf.
  - t_c = t clamped to [0, MAX_DEG].
  - width = MIN_PULSE_CYC + t_c*STEP_CYC, at least 21 bits unsigned.
- Frame load:
  - Only on the edge where cnt==PWM_PERIOD_CYC-1: pulse_reg <= width, oc_reg <= (measure_current > I_LIMIT), strict greater-than.
  - Input changes at any other time do not affect the frame in progress.
- Output: pwm_out = !oc_reg && (cnt < pulse_reg), decoded from registers only.
  - High for exactly pulse_reg cycles starting at cnt=0 of each frame.
- First frame after reset is idle (pulse_reg=0), so the first pulse starts PWM_PERIOD_CYC cycles after reset release.
- Over-current:
  - A frame loaded with oc_reg=1 is entirely low.
  - Recovery is automatic at the next frame load where current <= I_LIMIT.
  - No latching fault.
- Current exactly equal to I_LIMIT is not over-current.
- Not synthesizable as-is because of the real ports. Synthesis wrappers replace grades, measure_current and measure_grades with fixed-point equivalents without changing the datapath above.

Test Plan:
1. Hold rst_n=1 for 2 cycles, then release with grades=90, measure_grades=0, measure_current=1.0 -> pwm_out=0 throughout reset and for the first 2000000 cycles. At frame 2 (t=20 ms after release), pwm_out is high for 174925 cycles (e=90, t=135), then low for 1825075. Run 50 ms total.
2. grades=90, measure_grades=90 -> next frame high for 149950 cycles.
3. Clamps:
   - grades=180, measure_grades=0 -> t=270, clamped to 180 -> 199900 cycles.
   - grades=0, measure_grades=180 -> t=-90, clamped to 0 -> 100000 cycles.
   - grades=250, measure_grades=200 -> both clamp to 180 -> 199900.
   - grades=-10, measure_grades=0 -> 100000.
4. Over-current:
   - measure_current=2.5 before a frame load -> that whole frame low.
   - Back to 1.0 -> the following frame pulses normally.
   - measure_current=2.0 exactly -> pulse present.
5. Change grades 90 -> 0 at cnt=50000, mid-pulse -> current frame keeps its full width; the new width applies from the next frame.
6. Assert rst_n at cnt=120000 during a high phase -> pwm_out low on the next edge. cnt restarts at 0 after release, and the first frame after release is idle.
